// File: rtl/sysid_pkg.sv
// Shared constants, FSM state encoding and pass/fail helper for the system-ID checker.
package sysid_pkg;

    // Word addresses inside the system-ID slave
    localparam int unsigned SYSID_ADDR_ID = 0;
    localparam int unsigned SYSID_ADDR_TS = 1;

    // Values baked into the matching software build
    localparam logic [31:0] SYSID_EXP_ID = 32'd40899754;
    localparam logic [31:0] SYSID_EXP_TS = 32'd1242736836;

    // Checker FSM states; fixed 3-bit encoding so external logic can probe it
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } sysid_state_e;

    // Final verdict: a timestamp mismatch only counts when check_ts is set
    function automatic logic sysid_pass(input logic err_id,
                                        input logic err_ts,
                                        input logic err_timeout,
                                        input logic check_ts);
        return ~err_id & ~(check_ts & err_ts) & ~err_timeout;
    endfunction

endpackage

// File: rtl/sysid_checker_avm_single_read.sv
// Single Avalon-MM read engine: drives read/address while requested, tracks
// waitrequest stalls against a timeout and counts the fixed read latency.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int ADDR_W       = 1,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,             // owner is in a read-request state
    input  logic              lat,             // owner is waiting out read latency
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              accept,          // read accepted by the slave this cycle
    output logic              rdata_valid,     // rdata is the requested word this cycle
    output logic              timeout,         // stall limit reached this cycle
    output logic [31:0]       rdata
);

    // Last count values before the respective event fires
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAT_LAST = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;

    // Bus drive, handshake decode and counter next-state
    always_comb begin
        avm_read    = req;
        avm_address = addr;
        rdata       = avm_readdata;
        accept      = req & ~avm_waitrequest;
        timeout     = req & avm_waitrequest & (to_cnt_q == TO_LAST);
        // With zero latency the data rides on the accept cycle itself
        rdata_valid = (READ_LATENCY == 0) ? accept
                                          : (lat & (lat_cnt_q == LAT_LAST));

        // Stall counter restarts from zero every time a request phase begins
        to_cnt_d = '0;
        if (req & avm_waitrequest) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end

        // Latency counter runs only while the owner sits in a latency state
        lat_cnt_d = '0;
        if (lat) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            lat_cnt_q <= '0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// System-ID checker: on start, reads the ID and build timestamp words from the
// system-ID slave and reports sticky match/mismatch/timeout results.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter int          ADDR_W       = 1,
    parameter logic [31:0] EXP_ID       = SYSID_EXP_ID,
    parameter logic [31:0] EXP_TS       = SYSID_EXP_TS,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT_CYC  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err_id,
    output logic              err_ts,
    output logic              err_timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    sysid_state_e state_q, state_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        err_id_q, err_id_d;
    logic        err_ts_q, err_ts_d;
    logic        err_to_q, err_to_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;

    logic              rd_req;
    logic              rd_lat;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_accept;
    logic              rd_valid;
    logic              rd_timeout;
    logic [31:0]       rd_data;
    logic              go_fin;

    // Read engine control derived straight from state so reset drops the read at once
    always_comb begin
        rd_req  = (state_q == RD_ID)  || (state_q == RD_TS);
        rd_lat  = (state_q == LAT_ID) || (state_q == LAT_TS);
        rd_addr = ((state_q == RD_TS) || (state_q == LAT_TS)) ? ADDR_W'(SYSID_ADDR_TS)
                                                              : ADDR_W'(SYSID_ADDR_ID);
    end

    avm_single_read #(
        .ADDR_W      (ADDR_W),
        .READ_LATENCY(READ_LATENCY),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rd (
        .clk            (clk),
        .reset          (reset),
        .req            (rd_req),
        .lat            (rd_lat),
        .addr           (rd_addr),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .accept         (rd_accept),
        .rdata_valid    (rd_valid),
        .timeout        (rd_timeout),
        .rdata          (rd_data)
    );

    // Sequencing FSM: next state, capture and result flags
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_id_d = err_id_q;
        err_ts_d = err_ts_q;
        err_to_d = err_to_q;
        id_d     = id_q;
        ts_d     = ts_q;
        go_fin   = 1'b0;

        case (state_q)
            IDLE: begin
                // A new run wipes the previous results
                if (start) begin
                    state_d  = RD_ID;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_id_d = 1'b0;
                    err_ts_d = 1'b0;
                    err_to_d = 1'b0;
                    id_d     = '0;
                    ts_d     = '0;
                end
            end
            RD_ID: begin
                if (rd_timeout) begin
                    // Timestamp read is skipped after an ID timeout
                    err_to_d = 1'b1;
                    go_fin   = 1'b1;
                end else if (rd_valid) begin
                    id_d     = rd_data;
                    err_id_d = (rd_data != EXP_ID);
                    state_d  = RD_TS;
                end else if (rd_accept) begin
                    state_d  = LAT_ID;
                end
            end
            LAT_ID: begin
                if (rd_valid) begin
                    id_d     = rd_data;
                    err_id_d = (rd_data != EXP_ID);
                    state_d  = RD_TS;
                end
            end
            RD_TS: begin
                if (rd_timeout) begin
                    err_to_d = 1'b1;
                    go_fin   = 1'b1;
                end else if (rd_valid) begin
                    ts_d     = rd_data;
                    err_ts_d = (rd_data != EXP_TS);
                    go_fin   = 1'b1;
                end else if (rd_accept) begin
                    state_d  = LAT_TS;
                end
            end
            LAT_TS: begin
                if (rd_valid) begin
                    ts_d     = rd_data;
                    err_ts_d = (rd_data != EXP_TS);
                    go_fin   = 1'b1;
                end
            end
            FIN: begin
                // Always return to IDLE; a start seen here is dropped
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results become visible in the FIN cycle, using this cycle's captures
        if (go_fin) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = sysid_pass(err_id_d, err_ts_d, err_to_d, CHECK_TS);
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_id_q <= 1'b0;
            err_ts_q <= 1'b0;
            err_to_q <= 1'b0;
            id_q     <= '0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_id_q <= err_id_d;
            err_ts_q <= err_ts_d;
            err_to_q <= err_to_d;
            id_q     <= id_d;
            ts_q     <= ts_d;
        end
    end

    // Output mapping
    always_comb begin
        busy        = busy_q;
        done        = done_q;
        pass        = pass_q;
        err_id      = err_id_q;
        err_ts      = err_ts_q;
        err_timeout = err_to_q;
        id_value    = id_q;
        ts_value    = ts_q;
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: u0 uses latency 0 / CHECK_TS=1 / timeout 255,
// u1 uses latency 2 / CHECK_TS=0 / timeout 4. Each has a small slave model.
module tb_sysid_checker;
    import sysid_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT 0 : latency 0 ----------------
    logic        start0 = 1'b0;
    logic [0:0]  addr0;
    logic        rd0, wr0;
    logic [31:0] rdata0;
    logic        busy0, done0, pass0, eid0, ets0, eto0;
    logic [31:0] idv0, tsv0;
    logic [31:0] mem_id0 = SYSID_EXP_ID;
    logic [31:0] mem_ts0 = SYSID_EXP_TS;
    int          stall_n0 = 0;
    int          wcnt0;

    assign wr0    = rd0 && (wcnt0 < stall_n0);
    assign rdata0 = (rd0 && !wr0) ? (addr0[0] ? mem_ts0 : mem_id0) : 32'hDEADBEEF;
    always @(posedge clk) begin
        if (reset || !(rd0 && wr0)) wcnt0 <= 0;
        else                        wcnt0 <= wcnt0 + 1;
    end

    sysid_checker #(.ADDR_W(1), .CHECK_TS(1'b1), .READ_LATENCY(0), .TIMEOUT_CYC(255)) u0 (
        .clk(clk), .reset(reset), .start(start0),
        .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
        .busy(busy0), .done(done0), .pass(pass0), .err_id(eid0), .err_ts(ets0),
        .err_timeout(eto0), .id_value(idv0), .ts_value(tsv0)
    );

    // ---------------- DUT 1 : latency 2 ----------------
    logic        start1 = 1'b0;
    logic [0:0]  addr1;
    logic        rd1, wr1;
    logic [31:0] rdata1;
    logic        busy1, done1, pass1, eid1, ets1, eto1;
    logic [31:0] idv1, tsv1;
    logic [31:0] mem_id1 = SYSID_EXP_ID;
    logic [31:0] mem_ts1 = SYSID_EXP_TS;
    int          stall_n1 = 0;
    logic        stuck1 = 1'b0;
    int          wcnt1;
    logic        v1a, v1b, a1a, a1b;

    assign wr1 = rd1 && (stuck1 || (wcnt1 < stall_n1));
    always @(posedge clk) begin
        if (reset || !(rd1 && wr1)) wcnt1 <= 0;
        else                        wcnt1 <= wcnt1 + 1;
    end
    // Data appears exactly two cycles after the accept cycle, garbage otherwise
    always @(posedge clk) begin
        if (reset) begin
            v1a <= 1'b0; v1b <= 1'b0; a1a <= 1'b0; a1b <= 1'b0;
        end else begin
            v1a <= rd1 && !wr1;
            a1a <= addr1[0];
            v1b <= v1a;
            a1b <= a1a;
        end
    end
    assign rdata1 = v1b ? (a1b ? mem_ts1 : mem_id1) : 32'hDEADBEEF;

    sysid_checker #(.ADDR_W(1), .CHECK_TS(1'b0), .READ_LATENCY(2), .TIMEOUT_CYC(4)) u1 (
        .clk(clk), .reset(reset), .start(start1),
        .avm_address(addr1), .avm_read(rd1), .avm_waitrequest(wr1), .avm_readdata(rdata1),
        .busy(busy1), .done(done1), .pass(pass1), .err_id(eid1), .err_ts(ets1),
        .err_timeout(eto1), .id_value(idv1), .ts_value(tsv1)
    );

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the chosen DUT reports done, bounded by max_cyc
    task automatic wait_done(input int which, input int max_cyc, input int cyc0, output int cyc);
        cyc = cyc0;
        while (cyc < max_cyc && !(which == 0 ? done0 : done1)) begin
            tick();
            cyc++;
        end
        chk("wait_done", {31'd0, (which == 0 ? done0 : done1)}, 32'd1);
    endtask

    // Pulse start for one cycle and wait for done; cyc = cycles from start to done
    task automatic run(input int which, output int cyc);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(which, 200, 1, cyc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   cyc;
        int   rdn;
        logic ts_seen;

        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_done0", done0, 0);   chk("rst_pass0", pass0, 0);
        chk("rst_busy0", busy0, 0);   chk("rst_read0", rd0, 0);
        chk("rst_addr0", addr0, 0);   chk("rst_errs0", {eid0, ets0, eto0}, 0);
        chk("rst_idv0", idv0, 0);     chk("rst_tsv0", tsv0, 0);
        chk("rst_state0", 32'(u0.state_q), 32'(IDLE));
        chk("rst_read1", rd1, 0);     chk("rst_done1", done1, 0);

        // Matching slave, no stall: read at cycles 1 (addr 0) and 2 (addr 1), done at 3
        start0 = 1'b1; tick(); start0 = 1'b0;                 // cycle 1
        chk("t1_c1_read", rd0, 1);   chk("t1_c1_addr", addr0, 0);
        chk("t1_c1_busy", busy0, 1); chk("t1_c1_state", 32'(u0.state_q), 32'(RD_ID));
        tick();                                               // cycle 2
        chk("t1_c2_read", rd0, 1);   chk("t1_c2_addr", addr0, 1);
        tick();                                               // cycle 3
        chk("t1_c3_done", done0, 1); chk("t1_c3_pass", pass0, 1);
        chk("t1_c3_busy", busy0, 0); chk("t1_c3_read", rd0, 0);
        chk("t1_c3_state", 32'(u0.state_q), 32'(FIN));
        chk("t1_idv", idv0, 32'd40899754);
        chk("t1_tsv", tsv0, 32'd1242736836);
        chk("t1_errs", {eid0, ets0, eto0}, 0);
        // start during FIN is dropped; results hold
        start0 = 1'b1; tick(); start0 = 1'b0;                 // cycle 4
        chk("t1_fin_start_state", 32'(u0.state_q), 32'(IDLE));
        chk("t1_fin_start_busy", busy0, 0);
        chk("t1_hold_done", done0, 1); chk("t1_hold_pass", pass0, 1);
        tick();
        chk("t1_idle_read", rd0, 0);

        // Wrong ID: error flagged but timestamp still read
        mem_id0 = 32'h12345678;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t2_clr_done", done0, 0);
        chk("t2_clr_pass", pass0, 0);
        wait_done(0, 20, 1, cyc);
        chk("t2_cycles", cyc, 3);
        chk("t2_err_id", eid0, 1);   chk("t2_pass", pass0, 0);
        chk("t2_err_ts", ets0, 0);   chk("t2_idv", idv0, 32'h12345678);
        chk("t2_tsv", tsv0, SYSID_EXP_TS);
        mem_id0 = SYSID_EXP_ID;
        tick();

        // Wrong timestamp with CHECK_TS=1 fails
        mem_ts0 = 32'h0BAD0BAD;
        run(0, cyc);
        chk("t3a_err_ts", ets0, 1);  chk("t3a_err_id", eid0, 0);
        chk("t3a_pass", pass0, 0);   chk("t3a_tsv", tsv0, 32'h0BAD0BAD);
        mem_ts0 = SYSID_EXP_TS;
        tick();

        // Wrong timestamp with CHECK_TS=0 still passes; no-stall time 2+2*2+1 = 7
        mem_ts1 = 32'h0BAD0BAD;
        run(1, cyc);
        chk("t3b_cycles", cyc, 7);
        chk("t3b_err_ts", ets1, 1);  chk("t3b_pass", pass1, 1);
        chk("t3b_idv", idv1, SYSID_EXP_ID);
        mem_ts1 = SYSID_EXP_TS;
        tick();

        // 3 stall cycles per read, latency 2:
        // stalls 1-3, accept 4, latency 5-6, stalls 7-9, accept 10, latency 11-12, FIN 13
        stall_n1 = 3;
        start1 = 1'b1; tick(); start1 = 1'b0;                 // cycle 1
        cyc = 1;
        repeat (3) begin
            chk("t4_stall_read", rd1, 1);
            chk("t4_stall_addr", addr1, 0);
            tick();
            cyc++;
        end
        chk("t4_accept_read", rd1, 1);                        // cycle 4
        tick(); cyc++;                                        // cycle 5
        chk("t4_lat_read", rd1, 0);
        chk("t4_lat_state", 32'(u1.state_q), 32'(LAT_ID));
        wait_done(1, 100, cyc, cyc);
        chk("t4_cycles", cyc, 13);
        chk("t4_pass", pass1, 1);
        chk("t4_idv", idv1, SYSID_EXP_ID);
        chk("t4_tsv", tsv1, SYSID_EXP_TS);
        stall_n1 = 0;
        tick();

        // waitrequest stuck: 4 stall cycles on addr 0, then FIN with timeout
        stuck1 = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        rdn = 0;
        ts_seen = 1'b0;
        repeat (4) begin
            if (rd1) rdn++;
            if (rd1 && addr1[0]) ts_seen = 1'b1;
            tick();
        end                                                   // cycle 5
        chk("t5_read_cycles", rdn, 4);
        chk("t5_no_ts_read", ts_seen, 0);
        chk("t5_done", done1, 1);    chk("t5_timeout", eto1, 1);
        chk("t5_pass", pass1, 0);    chk("t5_read_off", rd1, 0);
        chk("t5_idv", idv1, 0);
        stuck1 = 1'b0;
        tick();

        // start while busy ignored; reset during stall on addr 1
        stall_n0 = 3;
        start0 = 1'b1; tick(); start0 = 1'b0;                 // cycle 1
        start0 = 1'b1; tick(); start0 = 1'b0;                 // cycle 2
        chk("t6_busy_state", 32'(u0.state_q), 32'(RD_ID));
        chk("t6_busy_read", rd0, 1);
        chk("t6_busy_done", done0, 0);
        tick(); tick(); tick();                               // cycle 5: stalled on addr 1
        chk("t6_ts_state", 32'(u0.state_q), 32'(RD_TS));
        chk("t6_ts_addr", addr0, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_read", rd0, 0);
        chk("t6_rst_flags", {busy0, done0, pass0, eid0, ets0, eto0}, 0);
        chk("t6_rst_idv", idv0, 0);
        chk("t6_rst_tsv", tsv0, 0);
        chk("t6_rst_state", 32'(u0.state_q), 32'(IDLE));
        stall_n0 = 0;
        run(0, cyc);
        chk("t6_fresh_cycles", cyc, 3);
        chk("t6_fresh_pass", pass0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
